mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port.
- Accepts one request at a time from the MEM stage over a valid/ready request channel, holds it for a programmable access latency, then commits the store or reads the word.
- Returns a sign/zero-extended result over a valid/ready response channel.
- Sits between the MEM-stage request logic and a word-organised RAM array held inside the block; it replaces the zero-latency combinational data cache with a multi-cycle slave.

---
 rtl/mem_responder_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 72 +++++++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder_pkg
//  Purpose  : Shared constants and types for the load/store responder and its
//             lane-alignment helper: bus width, RV32 funct3 codes, FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package mem_responder_pkg;

    // Width of the data and address buses
    localparam int DATA_SIZE = 32;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] FUNC3_B  = 3'b000;
    localparam logic [2:0] FUNC3_H  = 3'b001;
    localparam logic [2:0] FUNC3_W  = 3'b010;
    localparam logic [2:0] FUNC3_BU = 3'b100;
    localparam logic [2:0] FUNC3_HU = 3'b101;

    // Responder control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Combinational byte-lane steering for a word-organised RAM:
//             store byte enables and data replication, load extraction with
//             sign/zero extension, and misalignment / illegal-funct3 error.
//  Revision : 1.0  initial release
// ============================================================================
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic                 isWrite,
    input  logic [2:0]           func3,
    input  logic [1:0]           addrLow,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [DATA_SIZE-1:0] rdWord,
    output logic [3:0]           byteEn,
    output logic [DATA_SIZE-1:0] wdataLane,
    output logic [DATA_SIZE-1:0] rdataExt,
    output logic                 laneErr
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rdWord[{addrLow, 3'b000} +: 8];
    assign w_half = addrLow[1] ? rdWord[31:16] : rdWord[15:0];

    // Decode size from funct3; replicate store data so any enabled lane sees it
    always_comb begin
        byteEn    = 4'b0000;
        wdataLane = '0;
        rdataExt  = '0;
        laneErr   = 1'b0;
        case (func3)
            FUNC3_B: begin
                byteEn    = 4'b0001 << addrLow;
                wdataLane = {4{wdata[7:0]}};
                rdataExt  = {{24{w_byte[7]}}, w_byte};
            end
            FUNC3_H: begin
                laneErr   = addrLow[0];
                byteEn    = addrLow[1] ? 4'b1100 : 4'b0011;
                wdataLane = {2{wdata[15:0]}};
                rdataExt  = {{16{w_half[15]}}, w_half};
            end
            FUNC3_W: begin
                laneErr   = (addrLow != 2'b00);
                byteEn    = 4'b1111;
                wdataLane = wdata;
                rdataExt  = rdWord;
            end
            // Unsigned variants exist only for loads
            FUNC3_BU: begin
                laneErr   = isWrite;
                rdataExt  = {24'b0, w_byte};
            end
            FUNC3_HU: begin
                laneErr   = isWrite | addrLow[0];
                rdataExt  = {16'b0, w_half};
            end
            default: begin
                laneErr   = 1'b1;
            end
        endcase
        if (!isWrite || laneErr) begin
            byteEn = 4'b0000;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Multi-cycle load/store slave with an internal word RAM. Accepts
//             one request, waits LATENCY cycles, performs the access and holds
//             an extended result on a valid/ready response channel.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [2:0]           reqFunc3,
    input  logic [DATA_SIZE-1:0] reqAddr,
    input  logic [DATA_SIZE-1:0] reqWdata,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [DATA_SIZE-1:0] rspRdata,
    output logic                 rspErr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    state_t               r_state;
    logic [3:0]           r_count;
    logic                 r_write;
    logic [2:0]           r_func3;
    logic [DATA_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0] r_wdata;
    logic                 r_rspValid;
    logic [DATA_SIZE-1:0] r_rspRdata;
    logic                 r_rspErr;

    logic [29:0]          w_wordIdx;
    logic [IDX_W-1:0]     w_memIdx;
    logic                 w_rangeErr;
    logic                 w_err;
    logic                 w_access;
    logic [DATA_SIZE-1:0] w_rdWord;
    logic [3:0]           w_byteEn;
    logic [DATA_SIZE-1:0] w_wdataLane;
    logic [DATA_SIZE-1:0] w_rdataExt;
    logic                 w_laneErr;

    assign w_wordIdx  = r_addr[31:2];
    assign w_memIdx   = w_wordIdx[IDX_W-1:0];
    assign w_rangeErr = (32'(w_wordIdx) >= 32'(DEPTH));
    assign w_err      = w_laneErr | w_rangeErr;
    assign w_rdWord   = r_mem[w_memIdx];

    // The access happens on the last WAIT edge: the counter was loaded with
    // LATENCY-1 on accept, so response valid appears exactly LATENCY edges later.
    assign w_access   = (r_state == S_WAIT) && (r_count == 4'd0);

    mem_lane_align u_align (
        .isWrite   (r_write),
        .func3     (r_func3),
        .addrLow   (r_addr[1:0]),
        .wdata     (r_wdata),
        .rdWord    (w_rdWord),
        .byteEn    (w_byteEn),
        .wdataLane (w_wdataLane),
        .rdataExt  (w_rdataExt),
        .laneErr   (w_laneErr)
    );

    // RAM array: byte-lane writes on the access edge; contents survive reset
    always_ff @(posedge clk) begin
        if (w_access && r_write && !w_rangeErr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byteEn[i]) begin
                    r_mem[w_memIdx][8*i +: 8] <= w_wdataLane[8*i +: 8];
                end
            end
        end
    end

    // Request/response control: latch on accept, count down, respond, handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_write    <= 1'b0;
            r_func3    <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reqValid) begin
                        r_write <= reqWrite;
                        r_func3 <= reqFunc3;
                        r_addr  <= reqAddr;
                        r_wdata <= reqWdata;
                        r_count <= 4'(LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_count == 4'd0) begin
                        r_rspValid <= 1'b1;
                        r_rspErr   <= w_err;
                        r_rspRdata <= (r_write || w_err) ? '0 : w_rdataExt;
                        r_state    <= S_RESP;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rspReady) begin
                        r_rspValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign reqReady = (r_state == S_IDLE);
    assign rspValid = r_rspValid;
    assign rspRdata = r_rspRdata;
    assign rspErr   = r_rspErr;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder: directed vector table,
//             backpressure and mid-operation reset sequences, randomized
//             traffic against a byte-addressed reference memory, and a
//             LATENCY=1 instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        reqValid, reqReady, reqWrite, rspValid, rspReady, rspErr;
    logic [2:0]  reqFunc3;
    logic [31:0] reqAddr, reqWdata, rspRdata;

    logic        reqValid1, reqReady1, reqWrite1, rspValid1, rspReady1, rspErr1;
    logic [2:0]  reqFunc31;
    logic [31:0] reqAddr1, reqWdata1, rspRdata1;

    int checks = 0;
    int errors = 0;

    // Reference memory, byte addressed, little endian
    logic [7:0] refBytes [0:1023];

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqFunc3(reqFunc3), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .rspValid(rspValid), .rspReady(rspReady), .rspRdata(rspRdata), .rspErr(rspErr)
    );

    mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .reqValid(reqValid1), .reqReady(reqReady1), .reqWrite(reqWrite1),
        .reqFunc3(reqFunc31), .reqAddr(reqAddr1), .reqWdata(reqWdata1),
        .rspValid(rspValid1), .rspReady(rspReady1), .rspRdata(rspRdata1), .rspErr(rspErr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic er);
        vec_t v;
        v.w = w; v.f3 = f3; v.a = a; v.wd = wd; v.expRd = rd; v.expErr = er;
        return v;
    endfunction

    function automatic logic [31:0] preVal(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // Reference access: size and legality from funct3, alignment by modulo,
    // range by word index, data via byte array.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int  size;
        bit  legal;
        logic [31:0] v;
        size = 1; legal = 1'b1;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; legal = !w; end
            3'd5: begin size = 2; legal = !w; end
            default: legal = 1'b0;
        endcase
        er = !legal || ((a % size) != 0) || ((a / 4) >= 256);
        rd = '0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) refBytes[a[9:0] + 10'(i)] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v = v | (32'(refBytes[a[9:0] + 10'(i)]) << (8*i));
                if (f3[2] == 1'b0 && size == 1) v = 32'($signed(v[7:0]));
                if (f3[2] == 1'b0 && size == 2) v = 32'($signed(v[15:0]));
                rd = v;
            end
        end
    endtask

    // One transaction on the LATENCY=2 instance; lat = edges from accept to valid
    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int stall,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = '0; er = 1'b0; lat = -1;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = w; reqFunc3 = f3; reqAddr = a; reqWdata = wd;
        rspReady = 1'b0;
        n = 0;
        while (!reqReady && n < 50) begin @(negedge clk); n++; end
        if (!reqReady) begin failNow("req_accept"); reqValid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        lat = 0;
        while (!rspValid && lat < 50) begin @(negedge clk); lat++; end
        if (!rspValid) begin failNow("rsp_valid"); return; end
        repeat (stall) @(negedge clk);
        rd = rspRdata; er = rspErr;
        rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rspReady = 1'b0;
    endtask

    // Same transaction on the LATENCY=1 instance
    task automatic txn1(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        rd = '0; er = 1'b0; lat = -1;
        @(negedge clk);
        reqValid1 = 1'b1; reqWrite1 = w; reqFunc31 = f3; reqAddr1 = a; reqWdata1 = wd;
        rspReady1 = 1'b0;
        if (!reqReady1) begin failNow("req1_ready"); reqValid1 = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        reqValid1 = 1'b0;
        lat = 0;
        while (!rspValid1 && lat < 50) begin @(negedge clk); lat++; end
        if (!rspValid1) begin failNow("rsp1_valid"); return; end
        rd = rspRdata1; er = rspErr1;
        rspReady1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rspReady1 = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, mrd, held;
        logic        er, mer;
        int          lat, n;

        reset = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqFunc3 = 3'b0; reqAddr = '0; reqWdata = '0; rspReady = 1'b0;
        reqValid1 = 1'b0; reqWrite1 = 1'b0; reqFunc31 = 3'b0; reqAddr1 = '0; reqWdata1 = '0; rspReady1 = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_reqReady", reqReady, 1);
        check("rst_rspValid", rspValid, 0);
        check("rst_rspRdata", rspRdata, 0);
        check("rst_rspErr", rspErr, 0);
        check("rst_reqReady1", reqReady1, 1);
        check("rst_rspValid1", rspValid1, 0);
        reset = 1'b1;

        // ---- first store, latency check ----
        model(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, mrd, mer);
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        check("sw_latency", 32'(lat), 2);
        check("sw_err", er, 0);
        check("sw_rdata", rd, 0);

        // ---- preload remaining words used by later tests ----
        for (int i = 0; i < 16; i++) begin
            if (i != 4) begin
                model(1'b1, 3'b010, 32'(i*4), preVal(i), mrd, mer);
                txn(1'b1, 3'b010, 32'(i*4), preVal(i), 0, rd, er, lat);
                check("preload_err", er, 0);
            end
        end

        // ---- directed vector table ----
        vecs.push_back(mk(0, 3'b000, 32'h13, 0, 32'hFFFFFFDE, 0));
        vecs.push_back(mk(0, 3'b100, 32'h13, 0, 32'h000000DE, 0));
        vecs.push_back(mk(0, 3'b001, 32'h12, 0, 32'hFFFFDEAD, 0));
        vecs.push_back(mk(0, 3'b101, 32'h10, 0, 32'h0000BEEF, 0));
        vecs.push_back(mk(0, 3'b000, 32'h10, 0, 32'hFFFFFFEF, 0));
        vecs.push_back(mk(1, 3'b000, 32'h11, 32'h00000055, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h10, 0, 32'hDEAD55EF, 0));
        vecs.push_back(mk(1, 3'b001, 32'h12, 32'h00001234, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h10, 0, 32'h123455EF, 0));
        vecs.push_back(mk(0, 3'b000, 32'h11, 0, 32'h00000055, 0));
        vecs.push_back(mk(0, 3'b001, 32'h10, 0, 32'h000055EF, 0));
        vecs.push_back(mk(0, 3'b101, 32'h12, 0, 32'h00001234, 0));
        vecs.push_back(mk(0, 3'b010, 32'h02, 0, 0, 1));
        vecs.push_back(mk(0, 3'b010, 32'h00, 0, 32'hC0DE0000, 0));
        vecs.push_back(mk(0, 3'b001, 32'h01, 0, 0, 1));
        vecs.push_back(mk(0, 3'b011, 32'h10, 0, 0, 1));
        vecs.push_back(mk(0, 3'b010, 32'h400, 0, 0, 1));
        vecs.push_back(mk(1, 3'b010, 32'h400, 32'h11111111, 0, 1));
        vecs.push_back(mk(1, 3'b100, 32'h10, 32'h000000FF, 0, 1));
        vecs.push_back(mk(1, 3'b001, 32'h13, 32'h0000FFFF, 0, 1));
        vecs.push_back(mk(1, 3'b010, 32'h12, 32'hFFFFFFFF, 0, 1));
        vecs.push_back(mk(0, 3'b010, 32'h10, 0, 32'h123455EF, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            model(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, mrd, mer);
            txn(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, i % 3, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
            check($sformatf("vec%0d_err", i), er, vecs[i].expErr);
            check($sformatf("vec%0d_lat", i), 32'(lat), 2);
        end

        // ---- backpressure: response held, request not taken ----
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b0; reqFunc3 = 3'b010; reqAddr = 32'h10; rspReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reqAddr = 32'h00;
        n = 0;
        while (!rspValid && n < 50) begin @(negedge clk); n++; end
        if (!rspValid) failNow("bp_valid");
        held = rspRdata;
        check("bp_first_data", held, 32'h123455EF);
        for (int c = 0; c < 5; c++) begin
            check("bp_rspValid_hold", rspValid, 1);
            check("bp_rdata_stable", rspRdata, 32'h123455EF);
            check("bp_reqReady_low", reqReady, 0);
            @(negedge clk);
        end
        rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rspReady = 1'b0;
        check("bp_after_hs_valid", rspValid, 0);
        check("bp_after_hs_idle", reqReady, 1);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        check("bp_second_accepted", reqReady, 0);
        n = 0;
        while (!rspValid && n < 50) begin @(negedge clk); n++; end
        if (!rspValid) failNow("bp_second_valid");
        check("bp_second_data", rspRdata, 32'hC0DE0000);
        rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rspReady = 1'b0;

        // ---- reset while a store is waiting ----
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqFunc3 = 3'b010; reqAddr = 32'h20; reqWdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        check("mid_in_wait", reqReady, 0);
        #1 reset = 1'b0;
        #1;
        check("mid_async_idle", reqReady, 1);
        check("mid_async_valid", rspValid, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model(1'b0, 3'b010, 32'h20, 0, mrd, mer);
        txn(1'b0, 3'b010, 32'h20, 0, 0, rd, er, lat);
        check("mid_old_contents", rd, 32'hC0DE0008);
        check("mid_model_agree", rd, mrd);

        // ---- randomized traffic against the reference model ----
        for (int i = 0; i < 60; i++) begin
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a, wd;
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? (32'h400 + 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 63));
            wd = $urandom;
            model(w, f3, a, wd, mrd, mer);
            txn(w, f3, a, wd, $urandom_range(0, 3), rd, er, lat);
            check($sformatf("rnd%0d_rdata w=%0d f3=%0d a=%h", i, w, f3, a), rd, mrd);
            check($sformatf("rnd%0d_err", i), er, mer);
        end

        // ---- LATENCY=1 instance ----
        txn1(1'b1, 3'b010, 32'h0, 32'h11223344, rd, er, lat);
        check("l1_sw_latency", 32'(lat), 1);
        check("l1_sw_err", er, 0);
        txn1(1'b0, 3'b010, 32'h0, 0, rd, er, lat);
        check("l1_lw_data", rd, 32'h11223344);
        check("l1_lw_latency", 32'(lat), 1);
        txn1(1'b0, 3'b100, 32'h3, 0, rd, er, lat);
        check("l1_lbu_data", rd, 32'h00000011);
        txn1(1'b0, 3'b001, 32'h3, 0, rd, er, lat);
        check("l1_lh_misaligned", er, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
